// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants and types for the multi-cycle MIPS controller.
// The bne extension is enabled by defining MC_CTRL_BNE_EN.
package mc_ctrl_pkg;

  localparam int OPCODE_W = 6;
  localparam int STATE_W  = 4;

  // Opcode field values (IR[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  // ALUop codes consumed by the ALU function decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Controller states; IF must stay at encoding 0 so reset and idle agree
  typedef enum logic [STATE_W-1:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_EX_R     = 4'd2,
    S_WB_R     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_WB_LD    = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BR       = 4'd8,
    S_JMP      = 4'd9,
    S_EX_I     = 4'd10,
    S_WB_I     = 4'd11
  } state_t;

  // Control word produced by the state decoder (branch_ne is handled in the top)
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

  // True for opcodes the controller knows how to sequence
  function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ok = 1'b1;
`ifdef MC_CTRL_BNE_EN
      OP_BNE: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller <-> datapath bundle. The master side is the controller.
// pc_load is the combined PC enable (pc_write | pc_write_cond & (zero ^ branch_ne)),
// provided so the datapath does not have to rebuild it.
interface mc_ctrl_if
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W = OPCODE_W,
  parameter int ST_W = STATE_W
);
  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            mem_ready;

  logic [1:0]      alu_op;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic            pc_write;
  logic            pc_write_cond;
  logic            branch_ne;
  logic [1:0]      pc_source;
  logic            iord;
  logic            mem_read;
  logic            mem_write;
  logic            ir_write;
  logic            reg_write;
  logic            reg_dst;
  logic            mem_to_reg;
  logic            illegal;
  logic [ST_W-1:0] state;
  logic            pc_load;

  modport master (
    input  opcode, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, branch_ne,
           pc_source, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, illegal, state, pc_load
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, branch_ne,
           pc_source, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, illegal, state, pc_load
  );
endinterface

// File: rtl/mc_ctrl_out_dec.sv
// mc_ctrl_out_dec: state -> control word. Moore except for the IF-stage
// pc_write/ir_write (gated by mem_ready) and the ID-stage illegal flag.
module mc_ctrl_out_dec
  import mc_ctrl_pkg::*;
(
  input  state_t              state,
  input  logic                mem_ready,
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl
);

  // Decode the control word for the current state; anything not set stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_ID: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.illegal   = !op_legal(opcode);
      end
      S_EX_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_WB_R: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_MEM_ADDR, S_EX_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_WB_LD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_BR: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_WB_I: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller (state register + next-state logic).
// Define MC_CTRL_BNE_EN to accept bne (opcode 0x05) as a branch on !zero.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W = OPCODE_W,
  parameter int ST_W = STATE_W
)(
  input  logic            clk,
  input  logic            rst,
  mc_ctrl_if.master       bus
);

  state_t          state_q;
  ctrl_t           ctrl;
  ctrl_t           ctrl_g;
  logic            branch_ne;
  logic [OP_W-1:0] opcode;

  assign opcode = bus.opcode;

  mc_ctrl_out_dec u_dec (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .opcode    (opcode),
    .ctrl      (ctrl)
  );

`ifdef MC_CTRL_BNE_EN
  logic bne_q;

  // Remember whether the branch decoded in ID was a bne
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bne_q <= 1'b0;
    else if (state_q == S_ID)
      bne_q <= (opcode == OP_BNE);
  end

  assign branch_ne = !rst && (state_q == S_BR) && bne_q;
`else
  assign branch_ne = 1'b0;
`endif

  // Sequence the instruction; opcode is only looked at in ID and MEM_ADDR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
    end else begin
      case (state_q)
        S_IF:       if (bus.mem_ready) state_q <= S_ID;
        S_ID: begin
          case (opcode)
            OP_RTYPE:     state_q <= S_EX_R;
            OP_LW, OP_SW: state_q <= S_MEM_ADDR;
            OP_BEQ:       state_q <= S_BR;
`ifdef MC_CTRL_BNE_EN
            OP_BNE:       state_q <= S_BR;
`endif
            OP_J:         state_q <= S_JMP;
            OP_ADDI:      state_q <= S_EX_I;
            default:      state_q <= S_IF;
          endcase
        end
        S_EX_R:     state_q <= S_WB_R;
        S_WB_R:     state_q <= S_IF;
        S_MEM_ADDR: state_q <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (bus.mem_ready) state_q <= S_WB_LD;
        S_WB_LD:    state_q <= S_IF;
        S_MEM_WR:   if (bus.mem_ready) state_q <= S_IF;
        S_BR:       state_q <= S_IF;
        S_JMP:      state_q <= S_IF;
        S_EX_I:     state_q <= S_WB_I;
        S_WB_I:     state_q <= S_IF;
        default:    state_q <= S_IF;
      endcase
    end
  end

  // While reset is high every strobe is held low so an aborted access cannot complete
  assign ctrl_g = rst ? '0 : ctrl;

  assign bus.alu_op        = ctrl_g.alu_op;
  assign bus.alu_src_a     = ctrl_g.alu_src_a;
  assign bus.alu_src_b     = ctrl_g.alu_src_b;
  assign bus.pc_write      = ctrl_g.pc_write;
  assign bus.pc_write_cond = ctrl_g.pc_write_cond;
  assign bus.branch_ne     = branch_ne;
  assign bus.pc_source     = ctrl_g.pc_source;
  assign bus.iord          = ctrl_g.iord;
  assign bus.mem_read      = ctrl_g.mem_read;
  assign bus.mem_write     = ctrl_g.mem_write;
  assign bus.ir_write      = ctrl_g.ir_write;
  assign bus.reg_write     = ctrl_g.reg_write;
  assign bus.reg_dst       = ctrl_g.reg_dst;
  assign bus.mem_to_reg    = ctrl_g.mem_to_reg;
  assign bus.illegal       = ctrl_g.illegal;
  assign bus.state         = rst ? '0 : ST_W'(state_q);
  assign bus.pc_load       = ctrl_g.pc_write | (ctrl_g.pc_write_cond & (bus.zero ^ branch_ne));

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl. Expected per-cycle outputs are
// queued alongside the stimulus and compared once per cycle at the falling edge.
// Honours MC_CTRL_BNE_EN to match the build of the design.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic clk;
  logic rst;

  mc_ctrl_if #(.OP_W(6), .ST_W(4)) bus ();

  mc_ctrl #(.OP_W(6), .ST_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    string       tag;
    logic        rst;
    logic        mr;
    logic        zero;
    logic [5:0]  op;
    logic [22:0] exp;
  } cyc_t;

  cyc_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control outputs for a state, written straight from the state table
  function automatic logic [18:0] spec_word(state_t st, logic mr, logic zero,
                                            logic ill, logic bne);
    logic [1:0] alu_op, sb_sel, ps;
    logic sa, pw, pwc, bn, iord, mrd, mwr, irw, rw, rd, m2r, il, pl;
    {alu_op, sb_sel, ps} = '0;
    {sa, pw, pwc, bn, iord, mrd, mwr, irw, rw, rd, m2r, il, pl} = '0;
    case (st)
      S_IF:       begin mrd = 1; sb_sel = 2'b01; pw = mr; irw = mr; pl = mr; end
      S_ID:       begin sb_sel = 2'b11; il = ill; end
      S_EX_R:     begin sa = 1; alu_op = 2'b10; end
      S_WB_R:     begin rw = 1; rd = 1; end
      S_MEM_ADDR: begin sa = 1; sb_sel = 2'b10; end
      S_MEM_RD:   begin mrd = 1; iord = 1; end
      S_WB_LD:    begin rw = 1; m2r = 1; end
      S_MEM_WR:   begin mwr = 1; iord = 1; end
      S_BR:       begin sa = 1; alu_op = 2'b01; pwc = 1; ps = 2'b01; bn = bne; pl = zero ^ bne; end
      S_JMP:      begin pw = 1; ps = 2'b10; pl = 1; end
      S_EX_I:     begin sa = 1; sb_sel = 2'b10; end
      S_WB_I:     begin rw = 1; end
      default:    ;
    endcase
    return {alu_op, sa, sb_sel, pw, pwc, bn, ps, iord, mrd, mwr, irw, rw, rd, m2r, il, pl};
  endfunction

  task automatic pushCycle(input string tag, input logic r, input logic mr,
                           input logic zero, input logic [5:0] op, input state_t st,
                           input logic ill, input logic bne);
    cyc_t c;
    c.tag  = $sformatf("%s.%s", tag, r ? "RESET" : st.name());
    c.rst  = r;
    c.mr   = mr;
    c.zero = zero;
    c.op   = op;
    c.exp  = r ? 23'd0 : {4'(st), spec_word(st, mr, zero, ill, bne)};
    sb.push_back(c);
  endtask

  // Queue one whole instruction: ifWait/memWait stall cycles in IF and in the memory state
  task automatic applyStimulus(input string tag, input logic [5:0] op, input logic zero,
                               input int ifWait, input int memWait);
    for (int i = 0; i < ifWait; i++) pushCycle(tag, 0, 0, zero, op, S_IF, 0, 0);
    pushCycle(tag, 0, 1, zero, op, S_IF, 0, 0);
    case (op)
      6'h00: begin
        pushCycle(tag, 0, 1, zero, op, S_ID, 0, 0);
        pushCycle(tag, 0, 1, zero, op, S_EX_R, 0, 0);
        pushCycle(tag, 0, 1, zero, op, S_WB_R, 0, 0);
      end
      6'h23: begin
        pushCycle(tag, 0, 1, zero, op, S_ID, 0, 0);
        pushCycle(tag, 0, 1, zero, op, S_MEM_ADDR, 0, 0);
        for (int i = 0; i < memWait; i++) pushCycle(tag, 0, 0, zero, op, S_MEM_RD, 0, 0);
        pushCycle(tag, 0, 1, zero, op, S_MEM_RD, 0, 0);
        pushCycle(tag, 0, 1, zero, op, S_WB_LD, 0, 0);
      end
      6'h2B: begin
        pushCycle(tag, 0, 1, zero, op, S_ID, 0, 0);
        pushCycle(tag, 0, 1, zero, op, S_MEM_ADDR, 0, 0);
        for (int i = 0; i < memWait; i++) pushCycle(tag, 0, 0, zero, op, S_MEM_WR, 0, 0);
        pushCycle(tag, 0, 1, zero, op, S_MEM_WR, 0, 0);
      end
      6'h04: begin
        pushCycle(tag, 0, 1, zero, op, S_ID, 0, 0);
        pushCycle(tag, 0, 1, zero, op, S_BR, 0, 0);
      end
      6'h05: begin
`ifdef MC_CTRL_BNE_EN
        pushCycle(tag, 0, 1, zero, op, S_ID, 0, 0);
        pushCycle(tag, 0, 1, zero, op, S_BR, 0, 1);
`else
        pushCycle(tag, 0, 1, zero, op, S_ID, 1, 0);
`endif
      end
      6'h02: begin
        pushCycle(tag, 0, 1, zero, op, S_ID, 0, 0);
        pushCycle(tag, 0, 1, zero, op, S_JMP, 0, 0);
      end
      6'h08: begin
        pushCycle(tag, 0, 1, zero, op, S_ID, 0, 0);
        pushCycle(tag, 0, 1, zero, op, S_EX_I, 0, 0);
        pushCycle(tag, 0, 1, zero, op, S_WB_I, 0, 0);
      end
      default: pushCycle(tag, 0, 1, zero, op, S_ID, 1, 0);
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [22:0] got, input logic [22:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bound the run in case something upstream stops advancing
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cyc_t c;
    logic [22:0] obs;

    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    bus.opcode = 6'h00;

    for (int i = 0; i < 3; i++) pushCycle("reset", 1, 1, 0, 6'h00, S_IF, 0, 0);
    applyStimulus("add",     6'h00, 0, 0, 0);
    applyStimulus("lw",      6'h23, 0, 0, 2);
    applyStimulus("beq_z1",  6'h04, 1, 0, 0);
    applyStimulus("beq_z0",  6'h04, 0, 0, 0);
    applyStimulus("ill3f",   6'h3F, 0, 0, 0);
    applyStimulus("bne_z0",  6'h05, 0, 0, 0);
    applyStimulus("bne_z1",  6'h05, 1, 0, 0);
    applyStimulus("sw",      6'h2B, 0, 1, 1);
    applyStimulus("j",       6'h02, 0, 0, 0);
    applyStimulus("addi",    6'h08, 0, 0, 0);
    applyStimulus("lw_fast", 6'h23, 0, 0, 0);

    // A store aborted by reset while waiting on memory, then a clean restart
    pushCycle("abort", 0, 1, 0, 6'h2B, S_IF, 0, 0);
    pushCycle("abort", 0, 1, 0, 6'h2B, S_ID, 0, 0);
    pushCycle("abort", 0, 1, 0, 6'h2B, S_MEM_ADDR, 0, 0);
    pushCycle("abort", 0, 0, 0, 6'h2B, S_MEM_WR, 0, 0);
    pushCycle("abort", 1, 1, 0, 6'h2B, S_IF, 0, 0);
    applyStimulus("add2", 6'h00, 0, 0, 0);

    while (sb.size() > 0) begin
      c = sb.pop_front();
      @(negedge clk);
      rst           = c.rst;
      bus.mem_ready = c.mr;
      bus.zero      = c.zero;
      bus.opcode    = c.op;
      #1;
      obs = {bus.state, bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_write,
             bus.pc_write_cond, bus.branch_ne, bus.pc_source, bus.iord, bus.mem_read,
             bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
             bus.illegal, bus.pc_load};
      checkOutput(c.tag, obs, c.exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
